// File: rtl/remote_mem.sv
// remote_mem: TileLink-UL slave that forwards Get / PutFullData requests to a
// host as byte packets on a command FIFO, and rebuilds the TileLink response
// from the bytes the host returns on a response FIFO.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   a_*              TileLink A channel (opcode, size, source, address, mask,
//                    data, valid, ready)
//   d_*              TileLink D channel (opcode, size, source, data, denied,
//                    valid, ready)
//   full/wr_en/din   command FIFO write side (one byte per accepted strobe)
//   empty/rd_en/dout response FIFO read side, dout valid the cycle after rd_en
//
// Packet: cmd (0x01 read / 0x02 write), size, ADDR_W/8 address bytes LSB
// first, then N = 1<<size data bytes LSB first for writes. Reply: status byte,
// then N data bytes for a successful read.
module remote_mem #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int SRC_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_size,
    input  logic [SRC_W-1:0]    a_source,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [DATA_W/8-1:0] a_mask,
    input  logic [DATA_W-1:0]   a_data,
    input  logic                a_valid,
    output logic                a_ready,
    output logic [2:0]          d_opcode,
    output logic [2:0]          d_size,
    output logic [SRC_W-1:0]    d_source,
    output logic [DATA_W-1:0]   d_data,
    output logic                d_denied,
    output logic                d_valid,
    input  logic                d_ready,
    input  logic                full,
    output logic                wr_en,
    output logic [7:0]          din,
    input  logic                empty,
    output logic                rd_en,
    input  logic [7:0]          dout
);

    localparam logic [2:0] TL_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_GET             = 3'd4;
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

    localparam int AB      = ADDR_W / 8;
    localparam int DB      = DATA_W / 8;
    localparam int PKT_MAX = 2 + AB + DB;
    localparam int CNT_W   = $clog2(PKT_MAX);
    localparam int LOG_DB  = $clog2(DB);

    typedef enum logic [2:0] {IDLE, CMD, STATUS, DATA, RESP} state_t;

    state_t              state_reg, state_next;
    logic                is_write_reg;
    logic [2:0]          size_reg;
    logic [SRC_W-1:0]    source_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                rd_pend_reg;
    logic                denied_reg;
    logic [2:0]          opcode_reg;
    logic [7:0]          rdata_reg [DB];
    logic [7:0]          pkt_byte [PKT_MAX];
    logic [CNT_W-1:0]    n_bytes;
    logic [CNT_W-1:0]    last_idx;
    logic                legal;
    logic                accept;

    // PutFull implies a full mask, so the mask carries no information here.
    logic unused_mask;
    assign unused_mask = ^a_mask;

    assign accept   = (state_reg == IDLE) && a_valid;
    assign legal    = ((a_opcode == TL_GET) || (a_opcode == TL_PUT_FULL)) &&
                      (a_size <= 3'(LOG_DB));
    assign n_bytes  = CNT_W'(1) << size_reg;
    assign last_idx = is_write_reg ? CNT_W'(1 + AB) + n_bytes : CNT_W'(1 + AB);

    // Flat byte view of the outgoing packet, indexed by the byte counter.
    assign pkt_byte[0] = is_write_reg ? 8'h02 : 8'h01;
    assign pkt_byte[1] = {5'd0, size_reg};
    generate
        for (genvar gi = 0; gi < AB; gi++) begin : g_addr
            assign pkt_byte[2 + gi] = addr_reg[8*gi +: 8];
        end
        for (genvar gi = 0; gi < DB; gi++) begin : g_wdata
            assign pkt_byte[2 + AB + gi] = wdata_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        a_ready    = (state_reg == IDLE);
        d_valid    = (state_reg == RESP);
        wr_en      = (state_reg == CMD) && !full;
        din        = (state_reg == CMD) ? pkt_byte[cnt_reg] : 8'h00;
        // Only one read in flight: the cycle after a strobe is the capture cycle.
        rd_en      = ((state_reg == STATUS) || (state_reg == DATA)) &&
                     !empty && !rd_pend_reg;
        case (state_reg)
            IDLE:   if (a_valid) state_next = legal ? CMD : RESP;
            CMD:    if (!full && (cnt_reg == last_idx)) state_next = STATUS;
            STATUS: if (rd_pend_reg)
                        state_next = ((dout != 8'h00) || is_write_reg) ? RESP : DATA;
            DATA:   if (rd_pend_reg && (cnt_reg == n_bytes - CNT_W'(1)))
                        state_next = RESP;
            RESP:   if (d_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            is_write_reg <= 1'b0;
            size_reg     <= '0;
            source_reg   <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            cnt_reg      <= '0;
            rd_pend_reg  <= 1'b0;
            denied_reg   <= 1'b0;
            opcode_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            rd_pend_reg <= rd_en;
            case (state_reg)
                IDLE: if (a_valid) begin
                    is_write_reg <= (a_opcode == TL_PUT_FULL);
                    size_reg     <= a_size;
                    source_reg   <= a_source;
                    addr_reg     <= a_address;
                    wdata_reg    <= a_data;
                    cnt_reg      <= '0;
                    denied_reg   <= !legal;
                    opcode_reg   <= (a_opcode == TL_GET) ? TL_ACCESS_ACK_DATA
                                                         : TL_ACCESS_ACK;
                end
                // Counter wraps to 0 on the last byte so DATA starts at byte 0.
                CMD: if (!full) cnt_reg <= (cnt_reg == last_idx) ? '0 : cnt_reg + CNT_W'(1);
                STATUS: if (rd_pend_reg && (dout != 8'h00)) denied_reg <= 1'b1;
                DATA: if (rd_pend_reg) cnt_reg <= cnt_reg + CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Read data is cleared on acceptance, so bytes above N, and the whole word
    // after a nonzero status, read back as zero.
    generate
        for (genvar gi = 0; gi < DB; gi++) begin : g_rdata
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_reg[gi] <= 8'h00;
                end else if (accept) begin
                    rdata_reg[gi] <= 8'h00;
                end else if ((state_reg == DATA) && rd_pend_reg &&
                             (cnt_reg == CNT_W'(gi))) begin
                    rdata_reg[gi] <= dout;
                end
            end
            assign d_data[8*gi +: 8] = rdata_reg[gi];
        end
    endgenerate

    assign d_opcode = opcode_reg;
    assign d_size   = size_reg;
    assign d_source = source_reg;
    assign d_denied = denied_reg;

endmodule

// File: tb/tb_remote_mem.sv
module tb_remote_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  a_opcode, a_size;
    logic [7:0]  a_source;
    logic [63:0] a_address, a_data;
    logic [7:0]  a_mask;
    logic        a_valid, a_ready;
    logic [2:0]  d_opcode, d_size;
    logic [7:0]  d_source;
    logic [63:0] d_data;
    logic        d_denied, d_valid, d_ready;
    logic        full, wr_en, empty, rd_en;
    logic [7:0]  din, dout;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] cmd_q[$];
    logic [7:0] rsp_q[$];
    int  rd_total = 0;
    int  rd_bad = 0;
    bit  empty_stall = 0;

    always #5 clk = ~clk;

    remote_mem dut (
        .clk(clk), .rst_n(rst_n),
        .a_opcode(a_opcode), .a_size(a_size), .a_source(a_source),
        .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
        .a_valid(a_valid), .a_ready(a_ready),
        .d_opcode(d_opcode), .d_size(d_size), .d_source(d_source),
        .d_data(d_data), .d_denied(d_denied), .d_valid(d_valid), .d_ready(d_ready),
        .full(full), .wr_en(wr_en), .din(din),
        .empty(empty), .rd_en(rd_en), .dout(dout)
    );

    // Command FIFO: a byte is taken at the edge following a cycle with wr_en.
    always @(negedge clk) begin
        if (rst_n && wr_en) cmd_q.push_back(din);
    end

    // Response FIFO, standard mode: dout is the popped byte the cycle after rd_en.
    always @(posedge clk) begin
        int remaining;
        remaining = rsp_q.size();
        if (rd_en) begin
            rd_total++;
            if (empty || remaining == 0) rd_bad++;
            else begin
                dout <= rsp_q.pop_front();
                remaining--;
            end
        end
        empty <= (remaining == 0) || (empty_stall && ($urandom_range(0, 2) == 0));
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input logic [2:0] op, input logic [2:0] size, input logic [7:0] src,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [7:0] status, input logic [63:0] rdata,
                          input int fmode, input int dly);
        logic [7:0]  exp_pkt[$];
        logic        legal, is_wr, exp_denied;
        logic [2:0]  exp_opc;
        logic [63:0] exp_data;
        int n, exp_rd, cmd_start, rd_start, cyc, hold_cnt;
        bit held;
        logic [7:0] din_hold;

        legal = ((op == 3'd4) || (op == 3'd0)) && (size <= 3'd3);
        is_wr = (op == 3'd0);
        n = 1 << size;
        if (legal) begin
            exp_pkt.push_back(is_wr ? 8'h02 : 8'h01);
            exp_pkt.push_back({5'd0, size});
            for (int i = 0; i < 8; i++) exp_pkt.push_back(addr[8*i +: 8]);
            if (is_wr) for (int i = 0; i < n; i++) exp_pkt.push_back(wdata[8*i +: 8]);
            rsp_q.push_back(status);
            if (status == 8'h00 && !is_wr)
                for (int i = 0; i < n; i++) rsp_q.push_back(rdata[8*i +: 8]);
            if (status != 8'h00) begin
                rsp_q.push_back(8'hA5);
                rsp_q.push_back(8'h5A);
            end
        end
        exp_rd     = !legal ? 0 : ((status != 8'h00 || is_wr) ? 1 : 1 + n);
        exp_denied = !legal || (status != 8'h00);
        exp_opc    = (op == 3'd4) ? 3'd1 : 3'd0;
        if (status != 8'h00) exp_data = 64'd0;
        else if (n >= 8) exp_data = rdata;
        else exp_data = rdata & ((64'd1 << (8 * n)) - 64'd1);

        full = 1'b0;
        check("a_ready_idle", a_ready, 1'b1);
        cmd_start = cmd_q.size();
        rd_start  = rd_total;
        a_opcode = op; a_size = size; a_source = src; a_address = addr;
        a_data = wdata; a_mask = 8'hFF; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        a_address = {$urandom, $urandom};
        a_data = {$urandom, $urandom};
        check("a_ready_busy", a_ready, 1'b0);
        if (legal) check("first_byte_latency", wr_en, 1'b1);
        else check("denied_dvalid_latency", d_valid, 1'b1);

        cyc = 0; hold_cnt = 0; held = 0; din_hold = 8'h00;
        while (!d_valid && cyc < 400) begin
            if (fmode == 1) full = ($urandom_range(0, 3) == 0);
            else if (fmode == 2) begin
                if (!held && (cmd_q.size() - cmd_start) >= 4) begin
                    held = 1; hold_cnt = 3;
                end
                if (hold_cnt > 0) begin
                    full = 1'b1;
                    #1;
                    if (hold_cnt == 3) din_hold = din;
                    check("full_wr_en", wr_en, 1'b0);
                    check("full_din_pending", din, exp_pkt[cmd_q.size() - cmd_start]);
                    check("full_din_hold", din, din_hold);
                    hold_cnt--;
                end else full = 1'b0;
            end
            step();
            cyc++;
        end
        full = 1'b0;
        check("d_valid_timeout", d_valid, 1'b1);
        check("d_opcode", d_opcode, exp_opc);
        check("d_denied", d_denied, exp_denied);
        check("d_size", d_size, size);
        check("d_source", d_source, src);
        if (!is_wr && legal) check("d_data", d_data, exp_data);
        check("pkt_len", cmd_q.size() - cmd_start, exp_pkt.size());
        for (int i = 0; i < exp_pkt.size(); i++)
            if (cmd_start + i < cmd_q.size())
                check($sformatf("pkt[%0d]", i), cmd_q[cmd_start + i], exp_pkt[i]);
        check("rd_en_count", rd_total - rd_start, exp_rd);
        check("rd_while_empty", rd_bad, 0);

        for (int k = 0; k < dly; k++) begin
            step();
            check("hold_d_valid", d_valid, 1'b1);
            check("hold_a_ready", a_ready, 1'b0);
            check("hold_d_opcode", d_opcode, exp_opc);
            check("hold_d_denied", d_denied, exp_denied);
            check("hold_d_source", d_source, src);
            if (!is_wr && legal) check("hold_d_data", d_data, exp_data);
        end
        d_ready = 1'b1;
        step();
        d_ready = 1'b0;
        check("post_d_valid", d_valid, 1'b0);
        check("post_a_ready", a_ready, 1'b1);
        $display("txn op=%0d size=%0d src=%0h addr=%h status=%0h denied=%0d data=%h bytes=%0d",
                 op, size, src, addr, status, exp_denied, exp_data, exp_pkt.size());
        rsp_q.delete();
        step();
    endtask

    initial begin
        logic [2:0] op, sz;
        logic [7:0] st;
        logic [2:0] bad_ops [6];
        bad_ops = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        rst_n = 1'b0; a_valid = 1'b0; d_ready = 1'b0; full = 1'b0;
        a_opcode = '0; a_size = '0; a_source = '0; a_address = '0; a_data = '0; a_mask = '0;
        step(); step();
        check("rst_a_ready", a_ready, 1'b1);
        check("rst_d_valid", d_valid, 1'b0);
        check("rst_d_data", d_data, 64'd0);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_din", din, 8'h00);
        check("rst_rd_en", rd_en, 1'b0);
        rst_n = 1'b1;
        step();

        do_txn(3'd4, 3'd3, 8'h11, 64'hEFCDAB8967452301, 64'd0, 8'h00, 64'h0706050403020100, 0, 0);
        do_txn(3'd0, 3'd2, 8'h22, 64'h1000, 64'hDEADBEEF, 8'h00, 64'd0, 0, 0);
        do_txn(3'd4, 3'd0, 8'h33, 64'h40, 64'd0, 8'h00, 64'h5A, 0, 1);
        do_txn(3'd4, 3'd3, 8'h44, 64'h80, 64'd0, 8'h03, 64'h1234, 0, 0);
        do_txn(3'd0, 3'd3, 8'h55, 64'h123456789A, 64'h0102030405060708, 8'h00, 64'd0, 2, 0);
        do_txn(3'd4, 3'd1, 8'h66, 64'h2000, 64'd0, 8'h00, 64'hBEEF, 0, 5);
        do_txn(3'd7, 3'd2, 8'h77, 64'h3000, 64'hCAFE, 8'h00, 64'd0, 0, 0);
        do_txn(3'd4, 3'd4, 8'h78, 64'h3000, 64'd0, 8'h00, 64'd0, 0, 0);

        // Reset in the middle of a command packet.
        a_opcode = 3'd4; a_size = 3'd3; a_source = 8'h99; a_address = 64'hFFFF_0000_1111_2222;
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        step(); step();
        check("mid_pkt_wr_en", wr_en, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mrst_wr_en", wr_en, 1'b0);
        check("mrst_din", din, 8'h00);
        check("mrst_rd_en", rd_en, 1'b0);
        check("mrst_a_ready", a_ready, 1'b1);
        check("mrst_d_valid", d_valid, 1'b0);
        check("mrst_d_fields", {d_opcode, d_size, d_source, d_denied}, 15'd0);
        check("mrst_d_data", d_data, 64'd0);
        step(); step();
        rst_n = 1'b1;
        rsp_q.delete();
        step();
        do_txn(3'd4, 3'd2, 8'h9A, 64'h5000, 64'd0, 8'h00, 64'hA1B2C3D4, 0, 0);

        for (int t = 0; t < 24; t++) begin
            int r;
            r = $urandom_range(0, 9);
            op = (r < 5) ? 3'd4 : (r < 9) ? 3'd0 : bad_ops[$urandom_range(0, 5)];
            sz = 3'($urandom_range(0, 4));
            st = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            empty_stall = ($urandom_range(0, 1) == 1);
            do_txn(op, sz, 8'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                   st, {$urandom, $urandom}, $urandom_range(0, 1), $urandom_range(0, 3));
        end
        empty_stall = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
